bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Performs one shift per clock cycle and applies add3 digit correction to every BCD digit before each shift.
- Sits directly upstream of the BCD display/decode path. Takes a binary operand from the datapath and hands packed BCD digits downstream with a start/done handshake.

---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bin2bcd_seq_add3.sv | 12 +
 rtl/bin2bcd_seq.sv | 124 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Smallest digit count whose decimal range covers every WIDTH-bit value.
  function automatic int min_digits(input int width);
    longint unsigned max_val;
    longint unsigned pow10;
    int              d;
    max_val = (64'd1 << width) - 64'd1;
    pow10   = 64'd1;
    d       = 0;
    while (pow10 <= max_val) begin
      pow10 = pow10 * 64'd10;
      d     = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bin2bcd_seq_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one add3-then-shift step per clock,
// WIDTH steps per conversion, start/done handshake towards the display path.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  // Too few digits would let a nonzero bit fall off the top of scratch.
  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_bin_sh;
  logic [SCR_W-1:0]   r_scratch;
  logic [SCR_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_count;
  logic               r_done;

  logic               w_load;
  logic               w_shift;
  logic               w_finish;
  logic [SCR_W-1:0]   w_corr;
  logic [SCR_W-1:0]   w_scr_shift;
  logic [WIDTH-1:0]   w_bin_shift;

  // One correction cell per digit, plus the per-digit range check at completion.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bin2bcd_seq_add3 u_add3 (
      .i_digit (r_scratch[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .o_digit (w_corr[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );

    a_digit_le9 : assert property (@(posedge clk) disable iff (reset)
      w_finish |-> (w_scr_shift[BCD_DIGIT_W*g +: BCD_DIGIT_W] <= 4'd9));
  end

  // The bit shifted out of scratch is discarded; it must always be zero.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    w_shift |-> !w_corr[SCR_W-1]);

  // {scratch, bin_sh} shifted left by one after digit correction.
  assign w_scr_shift = {w_corr[SCR_W-2:0], r_bin_sh[WIDTH-1]};
  assign w_bin_shift = {r_bin_sh[WIDTH-2:0], 1'b0};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and step controls: accept in IDLE, count shifts in SHIFT.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_count == CNT_W'(1)) begin
          w_finish     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: capture operand, shift once per SHIFT cycle, publish on finish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin_sh  <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_bin_sh  <= bin;
        r_scratch <= '0;
        r_count   <= CNT_W'(WIDTH);
      end else if (w_shift) begin
        r_bin_sh  <= w_bin_shift;
        r_scratch <= w_scr_shift;
        r_count   <= r_count - CNT_W'(1);
      end
      if (w_finish) begin
        r_bcd <= w_scr_shift;
      end
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq at 8/3 and 10/4 configurations.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start8, start10;
  logic [7:0]  bin8;
  logic [9:0]  bin10;
  logic        busy8, busy10, done8, done10;
  logic [11:0] bcd8;
  logic [15:0] bcd10;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          bin;
    logic [11:0] exp;
  } vec_t;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk   (clk),
    .reset (rst),
    .start (start8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .bcd   (bcd8)
  );

  bin2bcd_seq #(.WIDTH(10), .DIGITS(4)) u_dut10 (
    .clk   (clk),
    .reset (rst),
    .start (start10),
    .bin   (bin10),
    .busy  (busy10),
    .done  (done10),
    .bcd   (bcd10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Reference: decimal digits by plain division, packed four bits each.
  function automatic logic [15:0] ref_bcd(input int v);
    int          x;
    logic [15:0] r;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // One conversion with a single-cycle start; observes a fixed window after accept.
  task automatic convert(input bit w10, input int v, output int lat, output int n_done,
                         output int n_busy, output logic [15:0] res);
    int limit;
    limit  = w10 ? 24 : 20;
    lat    = 0;
    n_done = 0;
    n_busy = 0;
    res    = '0;
    if (w10) begin
      bin10   = 10'(v);
      start10 = 1'b1;
    end else begin
      bin8   = 8'(v);
      start8 = 1'b1;
    end
    tick();
    start8  = 1'b0;
    start10 = 1'b0;
    bin8    = 8'($urandom);
    bin10   = 10'($urandom);
    for (int k = 1; k <= limit; k++) begin
      if (w10 ? busy10 : busy8) n_busy++;
      tick();
      if (w10 ? done10 : done8) begin
        n_done++;
        if (lat == 0) begin
          lat = k;
          res = w10 ? bcd10 : {4'h0, bcd8};
        end
      end
    end
  endtask

  initial begin
    vec_t        vecs[8];
    int          lat, nd, nb, t1, t2, gap;
    logic [15:0] res, r1, r2;
    int          perm[1024];

    vecs[0] = '{255, 12'h255};
    vecs[1] = '{0,   12'h000};
    vecs[2] = '{5,   12'h005};
    vecs[3] = '{9,   12'h009};
    vecs[4] = '{10,  12'h010};
    vecs[5] = '{99,  12'h099};
    vecs[6] = '{128, 12'h128};
    vecs[7] = '{200, 12'h200};

    rst = 1'b1; start8 = 1'b0; start10 = 1'b0; bin8 = '0; bin10 = '0;
    tick();
    tick();
    check("rst_busy8", 32'(busy8), 0);
    check("rst_done8", 32'(done8), 0);
    check("rst_bcd8", 32'(bcd8), 0);
    check("rst_busy10", 32'(busy10), 0);
    check("rst_bcd10", 32'(bcd10), 0);
    rst = 1'b0;
    tick();

    // Directed 8-bit vectors, including the add3 boundary at 5 and 10.
    for (int i = 0; i < 8; i++) begin
      convert(1'b0, vecs[i].bin, lat, nd, nb, res);
      check($sformatf("vec%0d_bcd", i), 32'(res), 32'(vecs[i].exp));
      check($sformatf("vec%0d_lat", i), lat, 8);
      check($sformatf("vec%0d_busy", i), nb, 8);
      check($sformatf("vec%0d_done", i), nd, 1);
      check($sformatf("vec%0d_hold", i), 32'(bcd8), 32'(vecs[i].exp));
    end

    // start while busy is ignored.
    bin8 = 8'd123; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    bin8 = 8'd200; start8 = 1'b1;
    tick();
    start8 = 1'b0; bin8 = 8'd0;
    lat = 0; nd = 0; res = '0;
    for (int k = 4; k <= 24; k++) begin
      tick();
      if (done8) begin
        nd++;
        if (lat == 0) begin lat = k; res = {4'h0, bcd8}; end
      end
    end
    check("ign_bcd", 32'(res), 32'h123);
    check("ign_lat", lat, 8);
    check("ign_done", nd, 1);

    // start held high: back-to-back conversions with only the done cycle idle.
    bin8 = 8'd99; start8 = 1'b1;
    tick();
    t1 = 0; t2 = 0; gap = 0; r1 = '0; r2 = '0;
    for (int k = 1; k <= 30 && t2 == 0; k++) begin
      tick();
      if (done8) begin
        if (t1 == 0) begin
          t1 = k; r1 = {4'h0, bcd8}; bin8 = 8'd100;
        end else begin
          t2 = k; r2 = {4'h0, bcd8}; start8 = 1'b0;
        end
      end
      if (t1 != 0 && t2 == 0 && !busy8) gap++;
    end
    check("b2b_t1", t1, 8);
    check("b2b_gap_cycles", t2 - t1, 9);
    check("b2b_bcd1", 32'(r1), 32'h099);
    check("b2b_bcd2", 32'(r2), 32'h100);
    check("b2b_idle", gap, 1);
    tick();
    tick();

    // Reset in the middle of a conversion aborts it.
    bin8 = 8'd200; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    check("abort_busy_pre", 32'(busy8), 1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy8), 0);
    check("abort_done", 32'(done8), 0);
    check("abort_bcd", 32'(bcd8), 0);
    tick();
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done8) nd++;
    end
    check("abort_nodone", nd, 0);
    check("abort_bcd_after", 32'(bcd8), 0);
    convert(1'b0, 42, lat, nd, nb, res);
    check("post_abort_bcd", 32'(res), 32'h042);
    check("post_abort_lat", lat, 8);

    // Random 8-bit operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      int v;
      v = int'($urandom_range(255, 0));
      convert(1'b0, v, lat, nd, nb, res);
      check($sformatf("rnd8_%0d_bcd", v), 32'(res), 32'(ref_bcd(v)));
      check($sformatf("rnd8_%0d_lat", v), lat, 8);
    end

    // 10-bit configuration: max value, then every value in random order.
    convert(1'b1, 1023, lat, nd, nb, res);
    check("w10_max_bcd", 32'(res), 32'h1023);
    check("w10_max_lat", lat, 10);
    check("w10_max_busy", nb, 10);
    check("w10_max_done", nd, 1);

    for (int i = 0; i < 1024; i++) perm[i] = i;
    for (int i = 1023; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 1024; i++) begin
      convert(1'b1, perm[i], lat, nd, nb, res);
      check($sformatf("sweep_%0d_bcd", perm[i]), 32'(res), 32'(ref_bcd(perm[i])));
      check($sformatf("sweep_%0d_lat", perm[i]), lat, 10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
